// File: rtl/cn_c2v_gen_if.sv
// cn_c2v_gen_if: handshake bundle for the check-node C2V generator.
//   Load side  : i_ld_vld / o_ld_rdy with the compressed record
//                (i_ld_abs = {min2, min1}, i_ld_idx, i_ld_sign_tot, i_ld_deg).
//   Read side  : i_rd_vld / o_rd_rdy with the requested edge (i_rd_col, i_rd_sign).
//   Output side: o_c2v_vld / i_c2v_rdy with o_c2v (sign-magnitude), o_c2v_col,
//                o_c2v_last.
// Modport slave is the generator; modport master is whoever drives it.
interface cn_c2v_gen_if #(
  parameter int MSG_WIDTH   = 6,
  parameter int COL_CNT_WID = 7
);
  logic                         i_ld_vld;
  logic                         o_ld_rdy;
  logic [(MSG_WIDTH-1)*2-1:0]   i_ld_abs;
  logic [COL_CNT_WID-1:0]       i_ld_idx;
  logic                         i_ld_sign_tot;
  logic [COL_CNT_WID-1:0]       i_ld_deg;
  logic                         i_rd_vld;
  logic                         o_rd_rdy;
  logic [COL_CNT_WID-1:0]       i_rd_col;
  logic                         i_rd_sign;
  logic                         o_c2v_vld;
  logic                         i_c2v_rdy;
  logic [MSG_WIDTH-1:0]         o_c2v;
  logic [COL_CNT_WID-1:0]       o_c2v_col;
  logic                         o_c2v_last;

  modport slave (
    input  i_ld_vld, i_ld_abs, i_ld_idx, i_ld_sign_tot, i_ld_deg,
    input  i_rd_vld, i_rd_col, i_rd_sign, i_c2v_rdy,
    output o_ld_rdy, o_rd_rdy, o_c2v_vld, o_c2v, o_c2v_col, o_c2v_last
  );

  modport master (
    output i_ld_vld, i_ld_abs, i_ld_idx, i_ld_sign_tot, i_ld_deg,
    output i_rd_vld, i_rd_col, i_rd_sign, i_c2v_rdy,
    input  o_ld_rdy, o_rd_rdy, o_c2v_vld, o_c2v, o_c2v_col, o_c2v_last
  );
endinterface

// File: rtl/cn_c2v_gen.sv
// cn_c2v_gen: check-node C2V generator (read side of the check-node sorter).
// Holds up to two compressed check-node records in a ping-pong buffer and
// expands the active record into one sign-magnitude C2V message per accepted
// read request, so one row can be loaded while the previous one is read out.
//
// Ports:
//   i_clk  - clock, all state updates on the rising edge
//   i_rst  - synchronous active-high reset
//   bus    - cn_c2v_gen_if.slave: load, read-request and C2V output handshakes
//
// Build option: define CN_OFFSET_EN for offset min-sum (magnitude reduced by
// OFFSET, saturating at zero). Without it, plain min-sum is produced and the
// OFFSET parameter has no effect.
module cn_c2v_gen #(
  parameter int MSG_WIDTH   = 6,
  parameter int COL_CNT_WID = 7,
  parameter int OFFSET      = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  cn_c2v_gen_if.slave    bus
);
  localparam int MAG_W = MSG_WIDTH - 1;
  localparam logic [MAG_W-1:0]       OFF_M   = MAG_W'(OFFSET);
  localparam logic [COL_CNT_WID-1:0] COL_ONE = COL_CNT_WID'(1);

  typedef enum logic {RD_IDLE, RD_RUN} rd_state_e;

  // Unsigned saturating offset: never wraps below zero.
  function automatic logic [MAG_W-1:0] sat_offset(input logic [MAG_W-1:0] mag);
    return (mag > OFF_M) ? (mag - OFF_M) : '0;
  endfunction

  // Record slots (data only, no reset needed: cnt guards their validity)
  logic [MAG_W-1:0]       min1_q [2];
  logic [MAG_W-1:0]       min2_q [2];
  logic [COL_CNT_WID-1:0] idx_q  [2];
  logic                   sign_q [2];
  logic [COL_CNT_WID-1:0] deg_q  [2];

  // Control state
  rd_state_e              state_q, state_d;
  logic                   wp_q, wp_d, rp_q, rp_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [COL_CNT_WID-1:0] edge_q, edge_d;

  // Output register
  logic                   vld_q, vld_d;
  logic [MSG_WIDTH-1:0]   c2v_q, c2v_d;
  logic [COL_CNT_WID-1:0] col_q, col_d;
  logic                   last_q, last_d;

  logic                   ld_rdy, rd_rdy, ld_fire, ld_wr, rd_fire;
  logic                   last_edge, release_ev;
  logic [MAG_W-1:0]       mag_sel, mag_out;
  logic                   sign_out;

  // Handshakes are held low while reset is asserted.
  assign ld_rdy  = ~i_rst & (cnt_q != 2'd2);
  assign rd_rdy  = ~i_rst & (state_q == RD_RUN) & (~vld_q | bus.i_c2v_rdy);
  assign ld_fire = bus.i_ld_vld & ld_rdy;
  // A zero-degree record is handshaken but never stored.
  assign ld_wr   = ld_fire & (bus.i_ld_deg != '0);
  assign rd_fire = bus.i_rd_vld & rd_rdy;

  // Release is count-based, so a degree overrun cannot occur.
  assign last_edge  = (edge_q == (deg_q[rp_q] - COL_ONE));
  assign release_ev = rd_fire & last_edge;

  // The edge holding min1 gets min2; every other edge gets min1.
  assign mag_sel = (bus.i_rd_col == idx_q[rp_q]) ? min2_q[rp_q] : min1_q[rp_q];
`ifdef CN_OFFSET_EN
  assign mag_out = sat_offset(mag_sel);
`else
  assign mag_out = mag_sel;
`endif
  // No negative zero.
  assign sign_out = (mag_out == '0) ? 1'b0 : (sign_q[rp_q] ^ bus.i_rd_sign);

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    vld_d   = vld_q;
    c2v_d   = c2v_q;
    col_d   = col_q;
    last_d  = last_q;
    state_d = state_q;

    if (ld_wr) wp_d = ~wp_q;
    if (release_ev) rp_d = ~rp_q;

    // Load and release together leave the occupancy unchanged.
    case ({ld_wr, release_ev})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    if (release_ev)   edge_d = '0;
    else if (rd_fire) edge_d = edge_q + COL_ONE;

    if (rd_fire) begin
      vld_d  = 1'b1;
      c2v_d  = {sign_out, mag_out};
      col_d  = bus.i_rd_col;
      last_d = last_edge;
    end else if (bus.i_c2v_rdy) begin
      vld_d  = 1'b0;
    end

    // Records become readable only from the cycle after they are written.
    case (state_q)
      RD_IDLE: if (cnt_d != 2'd0) state_d = RD_RUN;
      RD_RUN:  if (cnt_d == 2'd0) state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RD_IDLE;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= 2'd0;
      edge_q  <= '0;
      vld_q   <= 1'b0;
      c2v_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      vld_q   <= vld_d;
      c2v_q   <= c2v_d;
      col_q   <= col_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (ld_wr) begin
      min1_q[wp_q] <= bus.i_ld_abs[MAG_W-1:0];
      min2_q[wp_q] <= bus.i_ld_abs[2*MAG_W-1:MAG_W];
      idx_q[wp_q]  <= bus.i_ld_idx;
      sign_q[wp_q] <= bus.i_ld_sign_tot;
      deg_q[wp_q]  <= bus.i_ld_deg;
    end
  end

  assign bus.o_ld_rdy   = ld_rdy;
  assign bus.o_rd_rdy   = rd_rdy;
  assign bus.o_c2v_vld  = vld_q;
  assign bus.o_c2v      = c2v_q;
  assign bus.o_c2v_col  = col_q;
  assign bus.o_c2v_last = last_q;
endmodule

// File: tb/tb_cn_c2v_gen.sv
module tb_cn_c2v_gen;
  localparam int MW = 6, CW = 7, OFF = 1, TMO = 40;

`ifdef CN_OFFSET_EN
  localparam logic [5:0] X_S_B = 6'b000110, X_S_C = 6'b100010, X_PP_B = 6'b100011;
  localparam logic [5:0] X_OF_A = 6'b000000, X_OF_B = 6'b011110, X_RM = 6'b101000;
`else
  localparam logic [5:0] X_S_B = 6'b000111, X_S_C = 6'b100011, X_PP_B = 6'b100100;
  localparam logic [5:0] X_OF_A = 6'b100001, X_OF_B = 6'b011111, X_RM = 6'b101001;
`endif

  typedef struct packed {
    logic [4:0] min1; logic [4:0] min2; logic [6:0] idx; logic sign; logic [6:0] deg;
  } rec_t;
  typedef struct packed { logic [5:0] c2v; logic [6:0] col; logic last; } msg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  rec_t rec_q[$];
  msg_t exp_q[$];
  int   me = 0;
  int   chk_cnt = 0, pass_cnt = 0;
  msg_t mon_a, mon_e;

  cn_c2v_gen_if #(.MSG_WIDTH(MW), .COL_CNT_WID(CW)) bus ();
  cn_c2v_gen #(.MSG_WIDTH(MW), .COL_CNT_WID(CW), .OFFSET(OFF)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  // Reference C2V message for one edge of record r.
  function automatic logic [5:0] model_c2v(input rec_t r, input logic [6:0] col, input logic sgn);
    logic [4:0] m;
    logic       s;
    m = (col == r.idx) ? r.min2 : r.min1;
`ifdef CN_OFFSET_EN
    m = (m > 5'(OFF)) ? m - 5'(OFF) : 5'd0;
`endif
    s = (m == 5'd0) ? 1'b0 : (r.sign ^ sgn);
    return {s, m};
  endfunction

  // Scoreboard: every transferred message is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.o_c2v_vld === 1'b1 && bus.i_c2v_rdy === 1'b1) begin
      mon_a = {bus.o_c2v, bus.o_c2v_col, bus.o_c2v_last};
      chk_cnt++;
      if (exp_q.size() == 0)
        $display("FAIL sb_unexpected: got c2v=%b col=%0d last=%b want no message", mon_a.c2v, mon_a.col, mon_a.last);
      else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e)
          $display("FAIL sb_msg: got c2v=%b col=%0d last=%b want c2v=%b col=%0d last=%b",
                   mon_a.c2v, mon_a.col, mon_a.last, mon_e.c2v, mon_e.col, mon_e.last);
        else pass_cnt++;
      end
    end
  end

  // Drivers: entered and left at posedge+1.
  task automatic drive_load(input rec_t r, output int waited);
    int w;
    bus.i_ld_vld = 1'b1; bus.i_ld_abs = {r.min2, r.min1}; bus.i_ld_idx = r.idx;
    bus.i_ld_sign_tot = r.sign; bus.i_ld_deg = r.deg;
    for (w = 0; w < TMO; w++) begin
      @(negedge clk);
      if (bus.o_ld_rdy === 1'b1) break;
      @(posedge clk); #1;
    end
    waited = w;
    if (w == TMO) begin
      chk_cnt++;
      $display("FAIL ld_timeout: got o_ld_rdy=0 want 1 within %0d cycles", TMO);
    end else begin
      if (r.deg != 0) rec_q.push_back(r);
      @(posedge clk); #1;
    end
    bus.i_ld_vld = 1'b0;
  endtask

  task automatic drive_read(input logic [6:0] col, input logic sgn, output int waited);
    int   w;
    rec_t r;
    msg_t m;
    bus.i_rd_vld = 1'b1; bus.i_rd_col = col; bus.i_rd_sign = sgn;
    for (w = 0; w < TMO; w++) begin
      @(negedge clk);
      if (bus.o_rd_rdy === 1'b1) break;
      @(posedge clk); #1;
    end
    waited = w;
    if (w == TMO) begin
      chk_cnt++;
      $display("FAIL rd_timeout: got o_rd_rdy=0 want 1 within %0d cycles", TMO);
    end else begin
      if (rec_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL rd_no_record: got read accepted want no record readable");
      end else begin
        r = rec_q[0];
        m.c2v = model_c2v(r, col, sgn);
        m.col = col;
        m.last = (me == int'(r.deg) - 1);
        exp_q.push_back(m);
        if (m.last) begin void'(rec_q.pop_front()); me = 0; end
        else me++;
      end
      @(posedge clk); #1;
    end
    bus.i_rd_vld = 1'b0;
  endtask

  task automatic drain();
    int w;
    for (w = 0; w < TMO; w++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d pending want 0", exp_q.size());
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.i_ld_vld = 0; bus.i_ld_abs = '0; bus.i_ld_idx = '0; bus.i_ld_sign_tot = 0; bus.i_ld_deg = '0;
    bus.i_rd_vld = 0; bus.i_rd_col = '0; bus.i_rd_sign = 0; bus.i_c2v_rdy = 1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (bus.o_ld_rdy !== 1'b0) $display("FAIL rst_ld_rdy: got %b want 0", bus.o_ld_rdy); else pass_cnt++;
    chk_cnt++; if (bus.o_rd_rdy !== 1'b0) $display("FAIL rst_rd_rdy: got %b want 0", bus.o_rd_rdy); else pass_cnt++;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if (bus.o_c2v_vld !== 1'b0) $display("FAIL rst_vld: got %b want 0", bus.o_c2v_vld); else pass_cnt++;
    chk_cnt++; if (bus.o_c2v !== 6'd0) $display("FAIL rst_c2v: got %b want 0", bus.o_c2v); else pass_cnt++;
    chk_cnt++; if (bus.o_c2v_col !== 7'd0 || bus.o_c2v_last !== 1'b0)
      $display("FAIL rst_col_last: got %0d/%b want 0/0", bus.o_c2v_col, bus.o_c2v_last); else pass_cnt++;
    chk_cnt++; if (bus.o_ld_rdy !== 1'b1) $display("FAIL post_rst_ld_rdy: got %b want 1", bus.o_ld_rdy); else pass_cnt++;
    chk_cnt++; if (bus.o_rd_rdy !== 1'b0) $display("FAIL post_rst_rd_rdy: got %b want 0", bus.o_rd_rdy); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    rec_t a, z;
    int w1, w2;
    a = '{5'd3, 5'd7, 7'd5, 1'b1, 7'd3};
    // Read requested in the same cycle as the load into an empty buffer.
    fork
      drive_load(a, w1);
      drive_read(7'd4, 1'b0, w2);
    join
    chk_cnt++; if (w2 !== 1) $display("FAIL single_first_rd_wait: got %0d want 1", w2); else pass_cnt++;
    drive_read(7'd5, 1'b1, w1);
    @(negedge clk);
    chk_cnt++; if (bus.o_c2v !== X_S_B) $display("FAIL single_c2v_col5: got %b want %b", bus.o_c2v, X_S_B); else pass_cnt++;
    @(posedge clk); #1;
    drive_read(7'd9, 1'b0, w1);
    @(negedge clk);
    chk_cnt++; if (bus.o_c2v !== X_S_C || bus.o_c2v_last !== 1'b1)
      $display("FAIL single_c2v_col9: got %b last=%b want %b last=1", bus.o_c2v, bus.o_c2v_last, X_S_C); else pass_cnt++;
    chk_cnt++; if (bus.o_rd_rdy !== 1'b0) $display("FAIL single_empty: got o_rd_rdy=%b want 0", bus.o_rd_rdy); else pass_cnt++;
    @(posedge clk); #1;
    z = '{5'd1, 5'd2, 7'd0, 1'b0, 7'd0};
    drive_load(z, w1);
    @(negedge clk);
    chk_cnt++; if (bus.o_rd_rdy !== 1'b0 || bus.o_ld_rdy !== 1'b1)
      $display("FAIL deg0_discard: got rd_rdy=%b ld_rdy=%b want 0/1", bus.o_rd_rdy, bus.o_ld_rdy); else pass_cnt++;
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_ping_pong();
    rec_t a, b;
    int w;
    a = '{5'd2, 5'd9, 7'd1, 1'b0, 7'd2};
    b = '{5'd4, 5'd12, 7'd3, 1'b1, 7'd2};
    drive_load(a, w);
    drive_load(b, w);
    @(negedge clk);
    chk_cnt++; if (bus.o_ld_rdy !== 1'b0) $display("FAIL pp_full: got o_ld_rdy=%b want 0", bus.o_ld_rdy); else pass_cnt++;
    @(posedge clk); #1;
    drive_read(7'd1, 1'b0, w);
    drive_read(7'd2, 1'b1, w);
    fork
      begin
        @(negedge clk);
        chk_cnt++; if (bus.o_ld_rdy !== 1'b1) $display("FAIL pp_free: got o_ld_rdy=%b want 1", bus.o_ld_rdy); else pass_cnt++;
      end
      drive_read(7'd0, 1'b0, w);
    join
    chk_cnt++; if (w !== 0) $display("FAIL pp_b2b_wait: got %0d want 0", w); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (bus.o_c2v !== X_PP_B) $display("FAIL pp_b_first: got %b want %b", bus.o_c2v, X_PP_B); else pass_cnt++;
    @(posedge clk); #1;
    drive_read(7'd3, 1'b0, w);
    drain();
  endtask

  task automatic test_load_release();
    rec_t c, d;
    int w1, w2, w3;
    c = '{5'd5, 5'd6, 7'd2, 1'b0, 7'd2};
    d = '{5'd1, 5'd8, 7'd0, 1'b1, 7'd1};
    drive_load(c, w1);
    drive_read(7'd2, 1'b0, w1);
    fork
      drive_load(d, w1);
      drive_read(7'd7, 1'b1, w2);
    join
    chk_cnt++; if (w1 !== 0 || w2 !== 0) $display("FAIL lr_same_cycle: got waits %0d/%0d want 0/0", w1, w2); else pass_cnt++;
    fork
      begin
        @(negedge clk);
        chk_cnt++; if (bus.o_rd_rdy !== 1'b1 || bus.o_ld_rdy !== 1'b1)
          $display("FAIL lr_cnt1: got rd_rdy=%b ld_rdy=%b want 1/1", bus.o_rd_rdy, bus.o_ld_rdy); else pass_cnt++;
      end
      drive_read(7'd0, 1'b1, w3);
    join
    chk_cnt++; if (w3 !== 0) $display("FAIL lr_new_active: got wait %0d want 0", w3); else pass_cnt++;
    drain();
  endtask

  task automatic test_backpressure();
    rec_t e;
    int w;
    logic [5:0] held;
    logic [6:0] held_col;
    e = '{5'd3, 5'd10, 7'd4, 1'b1, 7'd4};
    drive_load(e, w);
    drive_read(7'd0, 1'b0, w);
    bus.i_c2v_rdy = 1'b0;
    held = bus.o_c2v; held_col = bus.o_c2v_col;
    fork
      begin
        repeat (4) begin
          @(negedge clk);
          chk_cnt++; if (bus.o_c2v !== held || bus.o_c2v_col !== held_col || bus.o_c2v_vld !== 1'b1)
            $display("FAIL bp_hold: got %b/%0d vld=%b want %b/%0d vld=1", bus.o_c2v, bus.o_c2v_col, bus.o_c2v_vld, held, held_col);
          else pass_cnt++;
          chk_cnt++; if (bus.o_rd_rdy !== 1'b0) $display("FAIL bp_rd_rdy: got %b want 0", bus.o_rd_rdy); else pass_cnt++;
          @(posedge clk); #1;
        end
        bus.i_c2v_rdy = 1'b1;
      end
      drive_read(7'd4, 1'b1, w);
    join
    chk_cnt++; if (w !== 4) $display("FAIL bp_stall_len: got %0d want 4", w); else pass_cnt++;
    drive_read(7'd5, 1'b0, w);
    drive_read(7'd6, 1'b1, w);
    drain();
  endtask

  task automatic test_offset();
    rec_t f, g;
    int w;
    f = '{5'd1, 5'd31, 7'd3, 1'b1, 7'd2};
    g = '{5'd0, 5'd5, 7'd1, 1'b1, 7'd1};
    drive_load(f, w);
    drive_load(g, w);
    drive_read(7'd0, 1'b0, w);
    @(negedge clk);
    chk_cnt++; if (bus.o_c2v !== X_OF_A) $display("FAIL off_min1: got %b want %b", bus.o_c2v, X_OF_A); else pass_cnt++;
    @(posedge clk); #1;
    drive_read(7'd3, 1'b1, w);
    @(negedge clk);
    chk_cnt++; if (bus.o_c2v !== X_OF_B) $display("FAIL off_min2: got %b want %b", bus.o_c2v, X_OF_B); else pass_cnt++;
    @(posedge clk); #1;
    drive_read(7'd2, 1'b0, w);
    @(negedge clk);
    chk_cnt++; if (bus.o_c2v !== 6'b000000) $display("FAIL neg_zero: got %b want 000000", bus.o_c2v); else pass_cnt++;
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_reset_mid();
    rec_t h, i, j;
    int w;
    h = '{5'd2, 5'd4, 7'd1, 1'b0, 7'd3};
    i = '{5'd6, 5'd7, 7'd2, 1'b1, 7'd1};
    j = '{5'd3, 5'd9, 7'd5, 1'b1, 7'd1};
    drive_load(h, w);
    drive_load(i, w);
    bus.i_c2v_rdy = 1'b0;
    drive_read(7'd1, 1'b0, w);
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if (bus.o_ld_rdy !== 1'b0 || bus.o_rd_rdy !== 1'b0)
      $display("FAIL mid_rst_rdy: got ld=%b rd=%b want 0/0", bus.o_ld_rdy, bus.o_rd_rdy); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); rec_q.delete(); me = 0;
    bus.i_c2v_rdy = 1'b1;
    @(negedge clk);
    chk_cnt++; if (bus.o_c2v_vld !== 1'b0 || bus.o_c2v !== 6'd0 || bus.o_c2v_col !== 7'd0 || bus.o_c2v_last !== 1'b0)
      $display("FAIL mid_rst_out: got vld=%b c2v=%b col=%0d last=%b want all 0", bus.o_c2v_vld, bus.o_c2v, bus.o_c2v_col, bus.o_c2v_last);
    else pass_cnt++;
    chk_cnt++; if (bus.o_ld_rdy !== 1'b1 || bus.o_rd_rdy !== 1'b0)
      $display("FAIL mid_rst_empty: got ld=%b rd=%b want 1/0", bus.o_ld_rdy, bus.o_rd_rdy); else pass_cnt++;
    @(posedge clk); #1;
    drive_load(j, w);
    drive_read(7'd5, 1'b0, w);
    @(negedge clk);
    chk_cnt++; if (bus.o_c2v !== X_RM || bus.o_c2v_last !== 1'b1)
      $display("FAIL mid_rst_new: got %b last=%b want %b last=1", bus.o_c2v, bus.o_c2v_last, X_RM); else pass_cnt++;
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_back_to_back();
    rec_t k, l;
    int w;
    logic [6:0] cols [5];
    cols = '{7'd0, 7'd1, 7'd2, 7'd1, 7'd3};
    k = '{5'd1, 5'd2, 7'd0, 1'b0, 7'd3};
    l = '{5'd4, 5'd5, 7'd1, 1'b1, 7'd2};
    drive_load(k, w);
    drive_load(l, w);
    for (int n = 0; n < 5; n++) begin
      drive_read(cols[n], 1'($urandom_range(0, 1)), w);
      chk_cnt++; if (w !== 0) $display("FAIL b2b_wait_%0d: got %0d want 0", n, w); else pass_cnt++;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_ping_pong();
    test_load_release();
    test_backpressure();
    test_offset();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
